// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the MEM-stage SRAM controller.
//   state_t        - access FSM states (IDLE / ACCESS / DONE)
//   BASE_ADDR_DEF  - byte address that maps to SRAM word 0
//   CNT_W          - wait-state counter width (covers WAIT_CYCLES up to 15)
//   word_addr()    - byte address to SRAM word address translation
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int          CNT_W         = 4;

  // Rebase to the SRAM window and drop the byte offset. There is no range
  // check; the caller truncates to the SRAM address width.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                            input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// mem_stage_sram_ctrl_if: single-port SRAM bus between the MEM stage and the
// data memory.
//   sram_addr  - word address (ADDR_W bits)
//   sram_wdata - write data
//   sram_we    - write strobe, active-high
//   sram_oe    - output enable, active-high
//   sram_rdata - read data returned by the SRAM
// Modports: master (controller side), slave (SRAM side).
interface mem_stage_sram_ctrl_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_we;
  logic              sram_oe;
  logic [31:0]       sram_rdata;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we,
    output sram_oe,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    input  sram_oe,
    output sram_rdata
  );

endinterface

// File: rtl/reg_pipe_4.sv
// reg_pipe_4: MEM/WB pipeline register.
//   clk, rst      - clock, synchronous active-high reset (clears everything)
//   en            - load enable (the stage ready signal)
//   *_in          - wb_en, mem_r_en, alu_res, mem_data, dest from MEM
//   *_out         - registered copies toward writeback
// While en is low the control bits are loaded with 0 so a bubble enters
// writeback; the data fields hold their last value.
module reg_pipe_4 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [3:0]        dest_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [3:0]        dest_out
);

  logic              wb_en_p1;
  logic              mem_r_en_p1;
  logic [DATA_W-1:0] alu_res_p1;
  logic [DATA_W-1:0] mem_data_p1;
  logic [3:0]        dest_p1;

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
      alu_res_p1  <= '0;
      mem_data_p1 <= '0;
      dest_p1     <= '0;
    end else if (en) begin
      wb_en_p1    <= wb_en_in;
      mem_r_en_p1 <= mem_r_en_in;
      alu_res_p1  <= alu_res_in;
      mem_data_p1 <= mem_data_in;
      dest_p1     <= dest_in;
    end else begin
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
    end
  end

  assign wb_en_out    = wb_en_p1;
  assign mem_r_en_out = mem_r_en_p1;
  assign alu_res_out  = alu_res_p1;
  assign mem_data_out = mem_data_p1;
  assign dest_out     = dest_p1;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM pipeline stage. Consumes the EX/MEM register,
// performs loads/stores against a single-port SRAM with WAIT_CYCLES fixed
// wait states, stalls upstream while an access is in flight and drives the
// MEM/WB register.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   wb_en_in, mem_r_en_in,
//   mem_w_en_in, alu_res_in,
//   val_rm_in, dest_in          - EX/MEM register outputs
//   ready                       - combinational; 0 freezes PC and upstream regs
//   wb_en_out, mem_r_en_out,
//   alu_res_out, mem_data_out,
//   dest_out                    - MEM/WB register outputs
//   sram                        - SRAM bus (mem_stage_sram_ctrl_if.master)
//
// Optional build macro MEM_STAGE_READ_BUF_EN: adds a one-entry last-access
// buffer (write-through). A load in IDLE whose word address matches a valid
// entry completes in the same cycle without touching the SRAM.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [31:0]           alu_res_in,
  input  logic [31:0]           val_rm_in,
  input  logic [3:0]            dest_in,
  output logic                  ready,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [31:0]           alu_res_out,
  output logic [31:0]           mem_data_out,
  output logic [3:0]            dest_out,
  mem_stage_sram_ctrl_if.master sram
);

  localparam int DATA_W = 32;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              is_wr_q;
  logic [31:0]       rdata_q;

  logic              req;
  logic              buf_hit;
  logic              last_beat;
  logic [ADDR_W-1:0] word_in;
  logic [31:0]       mem_data_sel;

  assign req       = mem_r_en_in | mem_w_en_in;
  assign word_in   = ADDR_W'(word_addr(alu_res_in, 32'(BASE_ADDR)));
  assign last_beat = (state_q == ACCESS) && (cnt_q == LAST_CNT);

`ifdef MEM_STAGE_READ_BUF_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_data;

  // A simultaneous read+write is a write, so it never counts as a hit.
  assign buf_hit = (state_q == IDLE) && mem_r_en_in && !mem_w_en_in &&
                   buf_vld && (buf_addr == word_in);
  assign mem_data_sel = buf_hit ? buf_data : rdata_q;

  // Only the valid bit is reset; address/data are qualified by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
    end else if ((state_q == IDLE) && mem_w_en_in) begin
      buf_vld  <= 1'b1;
      buf_addr <= word_in;
      buf_data <= val_rm_in;
    end else if (last_beat && !is_wr_q) begin
      buf_vld  <= 1'b1;
      buf_addr <= addr_q;
      buf_data <= sram.sram_rdata;
    end
  end
`else
  assign buf_hit      = 1'b0;
  assign mem_data_sel = rdata_q;
`endif

  always_comb begin
    state_d = state_q;
    ready   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req && !buf_hit) begin
          ready   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- SRAM access boundary: request latch, wait counter, read capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req && !buf_hit) begin
        addr_q  <= word_in;
        wdata_q <= val_rm_in;
        is_wr_q <= mem_w_en_in;
        cnt_q   <= '0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (last_beat && !is_wr_q) rdata_q <= sram.sram_rdata;
    end
  end

  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;
  assign sram.sram_we    = (state_q == ACCESS) && is_wr_q;
  assign sram.sram_oe    = (state_q == ACCESS) && !is_wr_q;

  reg_pipe_4 #(.DATA_W(DATA_W)) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .en           (ready),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .alu_res_in   (alu_res_in),
    .mem_data_in  (mem_data_sel),
    .dest_in      (dest_in),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out)
  );

endmodule
